sha256_block_ctrl: RTL and testbench
====================================

Name: sha256_block_ctrl

Overview:
- Sequences 512-bit padded blocks from sha256_preprocessing into the SHA-256 compression datapath.
- Per block: latches the block, loads IV on the first block of a message, loads working registers, steps 64 rounds, then commands the H += {a..h} update.
- After the last block of a message, presents digest-valid to the consumer and holds it until acknowledged.
- Owns all sequencing; the datapath is purely command-driven.

Parameters:
- NUM_ROUNDS, 64, rounds per block; the round counter terminal value is NUM_ROUNDS-1.
- RIDX_W, 6, width of round index; must satisfy 2^RIDX_W >= NUM_ROUNDS.
- BCNT_W, 16, width of per-message block counter.

Ports:
- clk  in  1  system clock, all logic rising-edge.
- reset  in  1  synchronous, active-high reset.
- block_in  in  512  padded message block from preprocessing.
- block_valid  in  1  block_in valid.
- block_last  in  1  block is final block of message; sampled with block_valid.
- block_accept  out  1  controller can take a block (valid&&accept = transfer).
- dp_block  out  512  registered copy of accepted block, stable until next accept.
- dp_load_iv  out  1  pulse: datapath loads H0..H7 with IV.
- dp_load_block  out  1  pulse: datapath loads a..h from H and W[0..15] from dp_block.
- dp_round_en  out  1  datapath executes one round this cycle.
- dp_round_idx  out  RIDX_W  current round index (selects K[t], W[t]).
- dp_update_h  out  1  pulse: datapath performs H_i += working var.
- digest_valid  out  1  H registers hold final digest of a message.
- digest_ack  in  1  consumer has taken the digest.
- busy  out  1  high in any state except IDLE.
- blk_cnt  out  BCNT_W  blocks completed in current message.

Behaviour:
- Reset values:
  - state=IDLE.
  - first_blk=1.
  - dp_block=0, dp_round_idx=0, blk_cnt=0.
  - All pulse outputs 0, digest_valid=0, busy=0.
  - block_accept=0 during reset cycle; =1 from first cycle after reset deasserts.
- States: IDLE, LOAD, ROUND, UPDATE, DONE.
- IDLE:
  - block_accept=1 (combinational on state).
  - On block_valid&&block_accept at cycle T:
    - latch dp_block<=block_in and last_r<=block_last;
    - dp_load_iv=1 in cycle T+1 iff first_blk;
    - -> LOAD.
- LOAD (T+1):
  - dp_load_block=1; dp_round_idx<=0; -> ROUND.
  - When dp_load_iv and dp_load_block are asserted in the same cycle, the datapath applies IV first.
- ROUND (T+2..T+1+NUM_ROUNDS):
  - dp_round_en=1; dp_round_idx increments by 1 each cycle.
  - At idx==NUM_ROUNDS-1: -> UPDATE; idx returns to 0.
- UPDATE (T+2+NUM_ROUNDS):
  - dp_update_h=1; blk_cnt<=blk_cnt+1, saturating at all-ones.
  - If last_r: -> DONE, first_blk<=1.
  - Else: -> IDLE, first_blk<=0.
- DONE:
  - digest_valid=1, block_accept=0.
  - On digest_ack: -> IDLE, digest_valid low next cycle, blk_cnt<=0.
- Latency and throughput (default 64 rounds):
  - Non-last block accepted at T: next accept possible at T+67, i.e. 67 cycles/block.
  - Last block accepted at T: digest_valid rises at T+67.
- Handshake rules:
  - block_in and block_last are only sampled on transfer.
  - block_valid while busy is ignored and not lost; the source holds it (standard valid/ready).
  - digest_ack outside DONE is ignored.
  - digest_ack is accepted in the same cycle digest_valid rises.
- Pulse outputs are exactly one cycle wide and mutually exclusive, except dp_load_iv with dp_load_block.
- dp_round_idx is held at 0 outside ROUND. dp_round_en is 0 outside ROUND.
- Single-block message: first_blk=1 and block_last=1 on the same block -> IV load + full sequence + DONE.
- Reset mid-operation (any state): returns to reset values next cycle; no update or digest pulse is issued.

Test Plan:
- Reset, then single block "abc" padded (block_last=1) at T → dp_load_iv and dp_load_block at T+1; dp_round_en for 64 cycles, idx 0..63; dp_update_h at T+66; digest_valid at T+67; with the reference datapath, digest = ba7816bf...f20015ad; blk_cnt=1.
- Two-block message (56-byte "abcdbcdecdef…nopq" padded), blocks offered back-to-back with block_valid held → second accept exactly at T+67; dp_load_iv only with the first block; digest = 248d6a61...19db06c1; blk_cnt=2.
- Hold digest_ack=0 for 20 cycles in DONE while block_valid=1 → block_accept stays 0, digest_valid stays 1. Then ack → IDLE next cycle and next block accepted with dp_load_iv=1.
- Assert reset during ROUND at idx=30 → next cycle all outputs at reset values; no dp_update_h. Following block gets dp_load_iv=1.
- digest_ack pulsed in IDLE and ROUND → no state change. block_valid toggled during ROUND → block_in not relatched; dp_block unchanged.
- Check pulse exclusivity and dp_round_idx==0 outside ROUND over a randomized 50-message run with random valid/ack gaps. Every last block must yield exactly one digest_valid rise.

Source files
------------

// File: rtl/sha256_block_ctrl_if.sv
// sha256_block_ctrl_if: block stream, datapath command and digest handshake bundle
interface sha256_block_ctrl_if #(
  parameter int RIDX_W = 6,
  parameter int BCNT_W = 16
);
  logic [511:0]      block_in;
  logic              block_valid;
  logic              block_last;
  logic              block_accept;
  logic [511:0]      dp_block;
  logic              dp_load_iv;
  logic              dp_load_block;
  logic              dp_round_en;
  logic [RIDX_W-1:0] dp_round_idx;
  logic              dp_update_h;
  logic              digest_valid;
  logic              digest_ack;
  logic              busy;
  logic [BCNT_W-1:0] blk_cnt;
  modport master (
    output block_in, block_valid, block_last, digest_ack,
    input  block_accept, dp_block, dp_load_iv, dp_load_block, dp_round_en,
           dp_round_idx, dp_update_h, digest_valid, busy, blk_cnt
  );
  modport slave (
    input  block_in, block_valid, block_last, digest_ack,
    output block_accept, dp_block, dp_load_iv, dp_load_block, dp_round_en,
           dp_round_idx, dp_update_h, digest_valid, busy, blk_cnt
  );
endinterface

// File: rtl/sha256_block_ctrl.sv
// sha256_block_ctrl: sequences padded blocks through a command-driven SHA-256 compression datapath
module sha256_block_ctrl #(
  parameter int NUM_ROUNDS = 64,
  parameter int RIDX_W     = 6,
  parameter int BCNT_W     = 16
) (
  input logic                clk,
  input logic                reset,
  sha256_block_ctrl_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, ROUND, UPDATE, DONE} state_t;
  localparam logic [RIDX_W-1:0] LAST_IDX = RIDX_W'(NUM_ROUNDS - 1);
  state_t            state_q, state_d;
  logic [511:0]      block_q;
  logic              last_q, first_q, first_d, xfer;
  logic [RIDX_W-1:0] idx_q, idx_d;
  logic [BCNT_W-1:0] cnt_q, cnt_d;
  assign bus.block_accept  = state_q == IDLE && !reset;
  assign xfer              = bus.block_valid && bus.block_accept;
  assign bus.dp_block      = block_q;
  assign bus.dp_load_iv    = state_q == LOAD && first_q;
  assign bus.dp_load_block = state_q == LOAD;
  assign bus.dp_round_en   = state_q == ROUND;
  assign bus.dp_round_idx  = idx_q;
  assign bus.dp_update_h   = state_q == UPDATE;
  assign bus.digest_valid  = state_q == DONE;
  assign bus.busy          = state_q != IDLE;
  assign bus.blk_cnt       = cnt_q;
  // next state; round index parks at 0 everywhere except while counting rounds
  always_comb begin
    state_d = state_q;
    first_d = first_q;
    idx_d   = '0;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE:    state_d = xfer ? LOAD : IDLE;
      LOAD:    state_d = ROUND;
      ROUND: begin
        idx_d   = idx_q == LAST_IDX ? '0 : idx_q + 1'b1;
        state_d = idx_q == LAST_IDX ? UPDATE : ROUND;
      end
      UPDATE: begin
        cnt_d   = &cnt_q ? cnt_q : cnt_q + 1'b1;
        state_d = last_q ? DONE : IDLE;
        first_d = last_q;
      end
      DONE: begin
        state_d = bus.digest_ack ? IDLE : DONE;
        cnt_d   = bus.digest_ack ? '0 : cnt_q;
      end
      default: state_d = IDLE;
    endcase
  end
  // state and block registers; the block is captured only on a transfer
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      first_q <= 1'b1;
      block_q <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      first_q <= first_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      if (xfer) begin
        block_q <= bus.block_in;
        last_q  <= bus.block_last;
      end
    end
  end
endmodule

// File: tb/tb_sha256_block_ctrl.sv
// tb_sha256_block_ctrl: scoreboard bench with a timing-level reference model of block sequencing
module tb_sha256_block_ctrl;
  localparam int NR  = 64;
  localparam int LAT = NR + 3;
  typedef struct {
    int   t;
    logic first;
  } rec_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  sha256_block_ctrl_if #(.RIDX_W(6), .BCNT_W(16)) bus ();
  sha256_block_ctrl #(.NUM_ROUNDS(NR), .RIDX_W(6), .BCNT_W(16)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  rec_t         exp_q[$];
  int           msg_t[$];
  int           cyc = 0, free_at = 0, lasts = 0, rises = 0, pushes = 0;
  int           checks = 0, errors = 0;
  logic         msg_done = 1'b0, first = 1'b1, armed = 1'b0, prev_dv = 1'b0;
  logic [511:0] exp_blk = '0;

  task automatic chk(input string n, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", n, got, exp, cyc);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32+:32] = $urandom;
    return r;
  endfunction

  // reference model: controller is free LAT cycles after each accept, then idle or holding a digest
  initial forever begin
    @(posedge clk);
    if (reset) begin
      if (msg_done && cyc < free_at) lasts--;
      exp_q.delete();
      msg_t.delete();
      free_at  = cyc + 1;
      msg_done = 1'b0;
      first    = 1'b1;
      exp_blk  = '0;
      armed    = 1'b1;
    end else if (armed) begin
      if (cyc >= free_at && !msg_done && bus.block_valid) begin
        exp_q.push_back('{cyc, first});
        msg_t.push_back(cyc);
        exp_blk  = bus.block_in;
        free_at  = cyc + LAT;
        msg_done = bus.block_last;
        first    = bus.block_last;
        lasts   += int'(bus.block_last);
        pushes++;
      end else if (cyc >= free_at && msg_done && bus.digest_ack) begin
        msg_done = 1'b0;
        msg_t.delete();
      end
    end
    cyc++;
  end

  // monitor: compares every output each cycle against the model's expectation
  initial forever begin
    @(negedge clk);
    if (reset) chk("accept_in_reset", 512'(bus.block_accept), 512'(1'b0));
    else if (armed) begin
      int p, n;
      logic e_iv, e_lb, e_ren, e_upd, e_acc, e_dv;
      logic [5:0] e_idx;
      p = 0; e_iv = 0; e_lb = 0; e_ren = 0; e_upd = 0; e_idx = '0; n = 0;
      e_acc = cyc >= free_at && !msg_done;
      e_dv  = cyc >= free_at && msg_done;
      if (exp_q.size() > 0) begin
        p     = cyc - exp_q[0].t;
        e_lb  = p == 1;
        e_iv  = p == 1 && exp_q[0].first;
        e_ren = p >= 2 && p <= NR + 1;
        e_idx = e_ren ? 6'(p - 2) : 6'd0;
        e_upd = p == NR + 2;
      end
      foreach (msg_t[i]) if (msg_t[i] + LAT <= cyc) n++;
      chk("ctrl", 512'({bus.block_accept, bus.dp_load_iv, bus.dp_load_block, bus.dp_round_en,
                        bus.dp_round_idx, bus.dp_update_h, bus.digest_valid, bus.busy, bus.blk_cnt}),
                  512'({e_acc, e_iv, e_lb, e_ren, e_idx, e_upd, e_dv, !e_acc, 16'(n)}));
      chk("dp_block", bus.dp_block, exp_blk);
      if (exp_q.size() > 0 && p == NR + 2) void'(exp_q.pop_front());
      if (bus.digest_valid && !prev_dv) rises++;
    end
    prev_dv = bus.digest_valid;
  end

  task automatic send(input logic last);
    int n0, w;
    n0 = pushes;
    w  = 0;
    bus.block_in    = rnd512();
    bus.block_last  = last;
    bus.block_valid = 1'b1;
    while (pushes == n0 && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (pushes == n0) chk("send_timeout", 512'(pushes), 512'(n0 + 1));
  endtask

  task automatic finish_msg();
    int w;
    w = 0;
    bus.block_valid = 1'b0;
    while ((cyc < free_at || !msg_done) && w < 500) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (w >= 500) chk("digest_timeout", 512'(msg_done), 512'(1'b1));
    bus.digest_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.digest_ack = 1'b0;
  endtask

  // stimulus: directed scenarios, then a randomized multi-message run
  initial begin
    int l0, g;
    bus.block_in    = '0;
    bus.block_valid = 1'b0;
    bus.block_last  = 1'b0;
    bus.digest_ack  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    send(1'b1);
    bus.block_in    = rnd512();
    bus.block_last  = 1'b0;
    bus.digest_ack  = 1'b0;
    repeat (LAT + 20) @(posedge clk);
    #1;
    bus.digest_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.digest_ack = 1'b0;
    send(1'b0);
    send(1'b1);
    repeat (30) begin
      @(posedge clk);
      #1;
      bus.block_valid = 1'($urandom);
      bus.digest_ack  = 1'($urandom);
      bus.block_in    = rnd512();
    end
    bus.digest_ack = 1'b0;
    finish_msg();
    send(1'b0);
    bus.block_valid = 1'b0;
    repeat (31) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    send(1'b1);
    finish_msg();
    l0 = lasts;
    g  = 0;
    while (lasts - l0 < 50 && g < 30000) begin
      @(posedge clk);
      #1;
      g++;
      bus.block_valid = $urandom_range(0, 3) != 0;
      bus.block_last  = $urandom_range(0, 2) == 0;
      bus.digest_ack  = $urandom_range(0, 5) == 0;
      bus.block_in    = rnd512();
    end
    chk("random_run_msgs", 512'(lasts - l0 >= 50), 512'(1'b1));
    bus.block_valid = 1'b0;
    bus.digest_ack  = 1'b1;
    repeat (LAT + 4) @(posedge clk);
    #1;
    bus.digest_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("digest_rises", 512'(rises), 512'(lasts));
    chk("final_busy", 512'(bus.busy), 512'(msg_done));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
